// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared definitions for the ID/EX pipeline register.
// Holds the default datapath widths, the ALU opcode encodings, the
// captured payload bundle and the forward-match helper used by the
// operand forwarding muxes.

package id_ex_stage_pkg;

    // Default datapath and register-index widths
    localparam int ID_EX_XLEN = 32;
    localparam int ID_EX_REGW = 5;
    localparam int ALU_OP_W   = 4;

    // ALU opcode encodings; the stage never checks these, it only carries them
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_SL  = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_SR  = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_BLT = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_MUL = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_BGT = 4'b1001;
    localparam logic [ALU_OP_W-1:0] ALU_BEQ = 4'b1100;

    // Everything the stage captures from decode for one instruction.
    // The field widths track the package defaults above.
    typedef struct packed {
        logic [ID_EX_XLEN-1:0] pc;
        logic [ID_EX_REGW-1:0] rs1;
        logic [ID_EX_REGW-1:0] rs2;
        logic [ID_EX_XLEN-1:0] data1;
        logic [ID_EX_XLEN-1:0] data2;
        logic [ID_EX_XLEN-1:0] imm;
        logic                  use_imm;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [ID_EX_REGW-1:0] rd;
        logic                  reg_write;
    } id_ex_payload_t;

    // A producer forwards to a source only if it writes, targets the same
    // register, and that register is not the hard-wired zero register.
    function automatic logic fwd_match(
        input logic                  we,
        input logic [ID_EX_REGW-1:0] src_rd,
        input logic [ID_EX_REGW-1:0] rs
    );
        return we && (src_rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// id_ex_stage_fwd_mux: operand forwarding mux for one source register.
// Picks the EX/MEM result first, then the MEM/WB result, otherwise the
// captured regfile data. The hit flag tells the stage that the value on
// the output came from a producer, so a held instruction can refresh its
// own copy before that producer retires.

import id_ex_stage_pkg::*;

module id_ex_stage_fwd_mux #(
    parameter int XLEN = ID_EX_XLEN,
    parameter int REGW = ID_EX_REGW
) (
    input  logic [REGW-1:0] rs,
    input  logic [XLEN-1:0] reg_data,
    input  logic            mem_we,
    input  logic [REGW-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] value,
    output logic            hit
);

    logic mem_match;
    logic wb_match;

    assign mem_match = fwd_match(mem_we, mem_rd, rs);
    assign wb_match  = fwd_match(wb_we, wb_rd, rs);

    // Priority select: the younger EX/MEM result wins over MEM/WB
    always_comb begin
        value = reg_data;
        hit   = 1'b0;
        if (mem_match) begin
            value = mem_data;
            hit   = 1'b1;
        end else if (wb_match) begin
            value = wb_data;
            hit   = 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: pipeline register between instruction decode and the ALU.
// Captures the decoded instruction on a valid/ready handshake, holds it
// while the ALU stalls, squashes it on flush, and presents the final ALU
// operands. Counts stalled cycles in a saturating counter.
//
// Build option: define ID_EX_FWD_EN to enable EX/MEM and MEM/WB operand
// forwarding, including refreshing the held operands while stalled.
// Without it the operands come straight from the captured regfile data
// (or immediate), the fwd_* ports are ignored and upstream must stall on
// RAW hazards.

import id_ex_stage_pkg::*;

module id_ex_stage #(
    parameter int XLEN        = ID_EX_XLEN,
    parameter int REGW        = ID_EX_REGW,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [REGW-1:0]        in_rs1,
    input  logic [REGW-1:0]        in_rs2,
    input  logic [XLEN-1:0]        in_rs1_data,
    input  logic [XLEN-1:0]        in_rs2_data,
    input  logic [XLEN-1:0]        in_imm,
    input  logic                   in_use_imm,
    input  logic [ALU_OP_W-1:0]    in_alu_op,
    input  logic [REGW-1:0]        in_rd,
    input  logic                   in_reg_write,

    input  logic                   flush,

    input  logic                   fwd_mem_we,
    input  logic [REGW-1:0]        fwd_mem_rd,
    input  logic [XLEN-1:0]        fwd_mem_data,
    input  logic                   fwd_wb_we,
    input  logic [REGW-1:0]        fwd_wb_rd,
    input  logic [XLEN-1:0]        fwd_wb_data,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_a,
    output logic [XLEN-1:0]        out_b,
    output logic [ALU_OP_W-1:0]    out_alu_op,
    output logic [XLEN-1:0]        out_pc,
    output logic [REGW-1:0]        out_rd,
    output logic                   out_reg_write,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    id_ex_payload_t         in_pl;
    id_ex_payload_t         pl_q;
    logic                   valid_q;
    logic [STALL_CNT_W-1:0] stall_q;

    logic                   accept;
    logic                   hold;

    logic [XLEN-1:0]        op1_val;
    logic [XLEN-1:0]        op2_val;
    logic                   op1_hit;
    logic                   op2_hit;

    // The stage can take a new instruction when empty or when the current
    // one leaves this cycle; flush deliberately does not gate this.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign hold     = valid_q && !out_ready;

    // Bundle the decode-side inputs into one payload word
    always_comb begin
        in_pl           = '0;
        in_pl.pc        = in_pc;
        in_pl.rs1       = in_rs1;
        in_pl.rs2       = in_rs2;
        in_pl.data1     = in_rs1_data;
        in_pl.data2     = in_rs2_data;
        in_pl.imm       = in_imm;
        in_pl.use_imm   = in_use_imm;
        in_pl.alu_op    = in_alu_op;
        in_pl.rd        = in_rd;
        in_pl.reg_write = in_reg_write;
    end

`ifdef ID_EX_FWD_EN
    id_ex_stage_fwd_mux #(
        .XLEN (XLEN),
        .REGW (REGW)
    ) u_fwd_a (
        .rs       (pl_q.rs1),
        .reg_data (pl_q.data1),
        .mem_we   (fwd_mem_we),
        .mem_rd   (fwd_mem_rd),
        .mem_data (fwd_mem_data),
        .wb_we    (fwd_wb_we),
        .wb_rd    (fwd_wb_rd),
        .wb_data  (fwd_wb_data),
        .value    (op1_val),
        .hit      (op1_hit)
    );

    id_ex_stage_fwd_mux #(
        .XLEN (XLEN),
        .REGW (REGW)
    ) u_fwd_b (
        .rs       (pl_q.rs2),
        .reg_data (pl_q.data2),
        .mem_we   (fwd_mem_we),
        .mem_rd   (fwd_mem_rd),
        .mem_data (fwd_mem_data),
        .wb_we    (fwd_wb_we),
        .wb_rd    (fwd_wb_rd),
        .wb_data  (fwd_wb_data),
        .value    (op2_val),
        .hit      (op2_hit)
    );
`else
    assign op1_val = pl_q.data1;
    assign op2_val = pl_q.data2;
    assign op1_hit = 1'b0;
    assign op2_hit = 1'b0;

    // Forwarding inputs and captured source indices have no consumer here
    logic unused_fwd;
    assign unused_fwd = ^{fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_we, fwd_wb_rd, fwd_wb_data,
                          pl_q.rs1, pl_q.rs2};
`endif

    // Stage register: flush beats accept; a stalled instruction keeps its
    // fields but absorbs forwarded operands so they survive producer retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pl_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            pl_q    <= in_pl;
        end else if (hold) begin
            if (op1_hit) begin
                pl_q.data1 <= op1_val;
            end
            if (op2_hit) begin
                pl_q.data2 <= op2_val;
            end
        end else begin
            valid_q <= 1'b0;
        end
    end

    // Saturating count of cycles the ALU refused a valid, unflushed instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (hold && !flush && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign out_valid     = valid_q;
    assign out_a         = op1_val;
    assign out_b         = pl_q.use_imm ? pl_q.imm : op2_val;
    assign out_alu_op    = pl_q.alu_op;
    assign out_pc        = pl_q.pc;
    assign out_rd        = pl_q.rd;
    assign out_reg_write = pl_q.reg_write && valid_q;
    assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage.
// Expected ALU-side results are queued when an instruction is offered and
// popped when the stage presents it. Expectations for forwarding follow
// the ID_EX_FWD_EN build option.

import id_ex_stage_pkg::*;

module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [3:0]  in_alu_op;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        flush;
    logic        fwd_mem_we;
    logic [4:0]  fwd_mem_rd;
    logic [31:0] fwd_mem_data;
    logic        fwd_wb_we;
    logic [4:0]  fwd_wb_rd;
    logic [31:0] fwd_wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_alu_op;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic [3:0]  stall_cnt;

    exp_t sb[$];
    exp_t e;
    exp_t o;
    int   checks;
    int   failures;

    id_ex_stage #(
        .XLEN        (32),
        .REGW        (5),
        .STALL_CNT_W (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .in_imm        (in_imm),
        .in_use_imm    (in_use_imm),
        .in_alu_op     (in_alu_op),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .flush         (flush),
        .fwd_mem_we    (fwd_mem_we),
        .fwd_mem_rd    (fwd_mem_rd),
        .fwd_mem_data  (fwd_mem_data),
        .fwd_wb_we     (fwd_wb_we),
        .fwd_wb_rd     (fwd_wb_rd),
        .fwd_wb_data   (fwd_wb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_a         (out_a),
        .out_b         (out_b),
        .out_alu_op    (out_alu_op),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .stall_cnt     (stall_cnt)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle_inputs();
        in_valid     = 1'b0;
        in_pc        = '0;
        in_rs1       = '0;
        in_rs2       = '0;
        in_rs1_data  = '0;
        in_rs2_data  = '0;
        in_imm       = '0;
        in_use_imm   = 1'b0;
        in_alu_op    = '0;
        in_rd        = '0;
        in_reg_write = 1'b0;
        flush        = 1'b0;
        fwd_mem_we   = 1'b0;
        fwd_mem_rd   = '0;
        fwd_mem_data = '0;
        fwd_wb_we    = 1'b0;
        fwd_wb_rd    = '0;
        fwd_wb_data  = '0;
        out_ready    = 1'b1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic use_imm, input logic [3:0] op, input logic [4:0] rd,
                         input logic rw);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_rs1_data  = d1;
        in_rs2_data  = d2;
        in_imm       = imm;
        in_use_imm   = use_imm;
        in_alu_op    = op;
        in_rd        = rd;
        in_reg_write = rw;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_a, out_b, out_alu_op, out_pc, out_rd, out_reg_write, stall_cnt} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: valid=%b a=%h b=%h op=%h pc=%h rd=%h rw=%b cnt=%0d, want all zero",
                     out_valid, out_a, out_b, out_alu_op, out_pc, out_rd, out_reg_write, stall_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_issue();
        @(negedge clk);
        offer(32'h100, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 1'b0, ALU_ADD, 5'd3, 1'b1);
        sb.push_back('{a: 32'd5, b: 32'd7, op: ALU_ADD, pc: 32'h100, rd: 5'd3, rw: 1'b1});
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_valid: got %b want 1", out_valid);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL single_pop: scoreboard empty");
        end else begin
            e = sb.pop_front();
            o = {out_a, out_b, out_alu_op, out_pc, out_rd, out_reg_write};
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL single_data: got %h want %h", o, e);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_stream();
        logic [3:0] ops [4];
        ops[0] = ALU_SUB;
        ops[1] = 4'hF;
        ops[2] = ALU_BEQ;
        ops[3] = ALU_OR;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            offer(32'h200 + 32'(4 * k), 5'(k + 1), 5'(k + 2), 32'h1000 + 32'(k), 32'h2000 + 32'(k),
                  32'h0, 1'b0, ops[k], 5'(k + 10), k[0]);
            sb.push_back('{a: 32'h1000 + 32'(k), b: 32'h2000 + 32'(k), op: ops[k],
                           pc: 32'h200 + 32'(4 * k), rd: 5'(k + 10), rw: k[0]});
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL stream_in_ready[%0d]: got %b want 1", k, in_ready);
            end
            if (k > 0) begin
                checks++;
                if (out_valid !== 1'b1 || sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL stream_valid[%0d]: out_valid=%b queued=%0d", k, out_valid, sb.size());
                end else begin
                    e = sb.pop_front();
                    o = {out_a, out_b, out_alu_op, out_pc, out_rd, out_reg_write};
                    if (o !== e) begin
                        failures++;
                        $display("[TB] FAIL stream_data[%0d]: got %h want %h", k, o, e);
                    end
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL stream_last: out_valid=%b queued=%0d", out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            o = {out_a, out_b, out_alu_op, out_pc, out_rd, out_reg_write};
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL stream_last_data: got %h want %h", o, e);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 4'd0) begin
            failures++;
            $display("[TB] FAIL stream_end: out_valid=%b stall_cnt=%0d, want 0 and 0", out_valid, stall_cnt);
        end
    endtask

    task automatic test_forward();
        logic [31:0] want;
        @(negedge clk);
        offer(32'h300, 5'd3, 5'd4, 32'h11, 32'h22, 32'h0, 1'b0, ALU_AND, 5'd5, 1'b1);
        @(negedge clk);
        offer(32'h304, 5'd0, 5'd0, 32'h33, 32'h44, 32'h0, 1'b0, ALU_ADD, 5'd6, 1'b1);
        fwd_mem_we   = 1'b1;
        fwd_mem_rd   = 5'd3;
        fwd_mem_data = 32'hAA;
        fwd_wb_we    = 1'b1;
        fwd_wb_rd    = 5'd3;
        fwd_wb_data  = 32'hBB;
        #1;
        want = FWD ? 32'hAA : 32'h11;
        checks++;
        if (out_a !== want) begin
            failures++;
            $display("[TB] FAIL fwd_mem_priority: out_a got %h want %h", out_a, want);
        end
        checks++;
        if (out_b !== 32'h22) begin
            failures++;
            $display("[TB] FAIL fwd_no_hit_b: out_b got %h want 00000022", out_b);
        end
        fwd_mem_we = 1'b0;
        #1;
        want = FWD ? 32'hBB : 32'h11;
        checks++;
        if (out_a !== want) begin
            failures++;
            $display("[TB] FAIL fwd_wb_select: out_a got %h want %h", out_a, want);
        end
        @(negedge clk);
        in_valid   = 1'b0;
        fwd_mem_we = 1'b1;
        fwd_mem_rd = 5'd0;
        fwd_wb_we  = 1'b1;
        fwd_wb_rd  = 5'd0;
        #1;
        checks++;
        if (out_a !== 32'h33 || out_b !== 32'h44) begin
            failures++;
            $display("[TB] FAIL fwd_reg0: out_a=%h out_b=%h want 00000033 00000044", out_a, out_b);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_stall_refresh();
        logic [31:0] want_b;
        want_b = FWD ? 32'h55 : 32'h20;
        @(negedge clk);
        offer(32'h400, 5'd6, 5'd7, 32'h10, 32'h20, 32'h0, 1'b0, ALU_SUB, 5'd8, 1'b1);
        sb.push_back('{a: 32'h10, b: want_b, op: ALU_SUB, pc: 32'h400, rd: 5'd8, rw: 1'b1});
        @(negedge clk);
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        fwd_wb_we   = 1'b1;
        fwd_wb_rd   = 5'd7;
        fwd_wb_data = 32'h55;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_b !== want_b) begin
            failures++;
            $display("[TB] FAIL stall_c1: valid=%b in_ready=%b out_b=%h want 1 0 %h", out_valid, in_ready, out_b, want_b);
        end
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            fwd_wb_we = 1'b0;
            offer(32'h4FC, 5'd9, 5'd9, 32'hDEAD, 32'hBEEF, 32'h0, 1'b0, ALU_OR, 5'd9, 1'b1);
            #1;
            checks++;
            if (out_b !== want_b || in_ready !== 1'b0 || out_pc !== 32'h400) begin
                failures++;
                $display("[TB] FAIL stall_c%0d: out_b=%h in_ready=%b out_pc=%h want %h 0 00000400",
                         c, out_b, in_ready, out_pc, want_b);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (stall_cnt !== 4'd3 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_count: stall_cnt=%0d in_ready=%b want 3 1", stall_cnt, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL stall_release: out_valid=%b queued=%0d", out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            o = {out_a, out_b, out_alu_op, out_pc, out_rd, out_reg_write};
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL stall_release_data: got %h want %h", o, e);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 4'd3) begin
            failures++;
            $display("[TB] FAIL stall_no_accept: out_valid=%b stall_cnt=%0d want 0 3", out_valid, stall_cnt);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        offer(32'h500, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 1'b0, ALU_ADD, 5'd9, 1'b1);
        @(negedge clk);
        offer(32'h5AA, 5'd1, 5'd2, 32'h3, 32'h4, 32'h0, 1'b0, ALU_SUB, 5'd10, 1'b1);
        flush = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_cycle: out_valid=%b in_ready=%b want 1 1", out_valid, in_ready);
        end
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_squash: out_valid=%b out_reg_write=%b want 0 0", out_valid, out_reg_write);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_discard: out_valid got %b want 0", out_valid);
        end
        offer(32'h600, 5'd1, 5'd2, 32'h5, 32'h6, 32'h0, 1'b0, ALU_OR, 5'd11, 1'b1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_stall_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 4'd3) begin
            failures++;
            $display("[TB] FAIL flush_stall: out_valid=%b stall_cnt=%0d want 0 3", out_valid, stall_cnt);
        end
    endtask

    task automatic test_imm_saturation();
        int want_cnt;
        @(negedge clk);
        offer(32'h700, 5'd1, 5'd2, 32'h7, 32'h99, 32'hFFFFFFFC, 1'b1, ALU_MUL, 5'd4, 1'b0);
        sb.push_back('{a: 32'h7, b: 32'hFFFFFFFC, op: ALU_MUL, pc: 32'h700, rd: 5'd4, rw: 1'b0});
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_b !== 32'hFFFFFFFC) begin
            failures++;
            $display("[TB] FAIL imm_operand: out_b got %h want fffffffc", out_b);
        end
        for (int s = 1; s <= 20; s++) begin
            @(negedge clk);
            #1;
            want_cnt = (3 + s > 15) ? 15 : 3 + s;
            checks++;
            if (stall_cnt !== 4'(want_cnt)) begin
                failures++;
                $display("[TB] FAIL sat_count[%0d]: stall_cnt got %0d want %0d", s, stall_cnt, want_cnt);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL imm_release: out_valid=%b queued=%0d", out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            o = {out_a, out_b, out_alu_op, out_pc, out_rd, out_reg_write};
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL imm_release_data: got %h want %h", o, e);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== 4'd15 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sat_hold: stall_cnt=%0d out_valid=%b want 15 0", stall_cnt, out_valid);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        offer(32'h800, 5'd1, 5'd2, 32'h8, 32'h9, 32'h0, 1'b0, ALU_BLT, 5'd12, 1'b1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_reg_write !== 1'b1) begin
            failures++;
            $display("[TB] FAIL areset_pre: out_valid=%b out_reg_write=%b want 1 1", out_valid, out_reg_write);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || stall_cnt !== 4'd0 || out_pc !== 32'h0) begin
            failures++;
            $display("[TB] FAIL areset_clear: valid=%b rw=%b cnt=%0d pc=%h want 0 0 0 0",
                     out_valid, out_reg_write, stall_cnt, out_pc);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
    endtask

    // Run all scenarios in order, then report
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_issue();
        test_stream();
        test_forward();
        test_stall_refresh();
        test_flush();
        test_imm_saturation();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty: %0d entries left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
